// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory from a
// byte PC and queues {pc, instr} pairs in a small prefetch FIFO for the decoder.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        imem_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] retired_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        retired_q, retired_d;
    logic               fault_q, fault_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        buf_pc_q    [DEPTH];
    logic [31:0]        buf_instr_q [DEPTH];

    logic redirect_hit, misaligned, full, push, pop;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case/if tree can leave a value unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        redirect_hit = redirect_valid && (state_q != FAULT);
        misaligned   = redirect_hit && (redirect_pc[1:0] != 2'b00);
        full         = (count_q == CNT_W'(DEPTH));
        out_valid    = (count_q != '0) && (state_q != FAULT);
        pop          = out_valid && out_ready && !redirect_valid;
        push         = (state_q == FETCH) && !redirect_valid && (!full || pop);

        if (redirect_hit) begin
            // A redirect discards everything fetched down the old path.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (misaligned) begin
                fault_d = 1'b1;
                state_d = FAULT;
            end else begin
                pc_d = redirect_pc;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
                pc_d   = pc_q + 32'd4;
            end
            if (pop) begin
                head_d    = head_q + PTR_W'(1);
                retired_d = retired_q + 32'd1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);

            unique case (state_q)
                IDLE:    if (start && !halt_req) state_d = FETCH;
                FETCH:   if (halt_req)           state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            fault_q   <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // NOTE: the buffer is only a few flops, so it is reset too; that keeps the
    // head outputs at a known zero instead of X straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[tail_q]    <= pc_q;
            buf_instr_q[tail_q] <= imem_rdata;
        end
    end

    // Head is registered data only; the memory never reaches out_* in one cycle.
    assign out_pc      = out_valid ? buf_pc_q[head_q]    : '0;
    assign out_instr   = out_valid ? buf_instr_q[head_q] : '0;
    assign imem_addr   = {2'b00, pc_q[31:2]};
    assign imem_en     = push;
    assign fault       = fault_q;
    assign retired_cnt = retired_q;

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte PC loaded at reset.
REQ-002 Parameter: DEPTH, 2, prefetch buffer entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; moves IDLE to FETCH.
REQ-006 halt_req  input  1  level; moves FETCH to IDLE.
REQ-007 redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 imem_addr  output  32  word index to instruction memory (pc >> 2).
REQ-010 imem_rdata  input  32  combinational read data for imem_addr, same cycle.
REQ-011 imem_en  output  1  high in cycles where imem_rdata is captured.
REQ-012 out_valid  output  1  buffer head holds an instruction.
REQ-013 out_ready  input  1  consumer accepts head.
REQ-014 out_instr  output  32  head instruction word.
REQ-015 out_pc  output  32  byte PC of head instruction.
REQ-016 fault  output  1  sticky misaligned-redirect flag.
REQ-017 retired_cnt  output  32  count of accepted instructions (out_valid & out_ready).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, FAULT; IDLE->FETCH when start=1; FETCH->IDLE when halt_req=1 (halt_req wins over start); FAULT exits only via reset.
REQ-019 imem_addr SHALL equal {2'b00, pc[31:2]} continuously, in every state.
REQ-020 push SHALL occur when state=FETCH, redirect_valid=0, and (buffer not full or pop in same cycle); imem_en SHALL equal push.
REQ-021 On push: entry {pc, imem_rdata} written at tail; pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-022 pop SHALL occur when out_valid & out_ready & redirect_valid=0; out_instr/out_pc SHALL be driven from the head with no combinational path from imem_rdata.
REQ-023 Simultaneous push and pop on full buffer SHALL both take effect, occupancy unchanged; on empty buffer push and pop SHALL NOT bypass (out_valid rises next cycle).
REQ-024 Fetch latency: first instruction visible on out_valid exactly one cycle after the first push edge.
REQ-025 redirect_valid=1 (state IDLE or FETCH) SHALL have top priority: buffer flushed to empty, no push, no pop, retired_cnt unchanged, pc <= redirect_pc; state unchanged.
REQ-026 redirect_pc[1:0] != 0 with redirect_valid=1 SHALL instead set fault=1, flush buffer, leave pc unchanged, enter FAULT.
REQ-027 In FAULT: no push, redirect ignored, buffered entries already flushed, out_valid=0.
REQ-028 In IDLE buffer contents SHALL be retained and drainable via out_ready; no push.
REQ-029 retired_cnt SHALL increment by 1 per pop, wrapping 32'hFFFF_FFFF -> 0.

Reset
REQ-030 rst_n=0 SHALL immediately, independent of clk: state=IDLE, pc=RESET_PC, buffer empty, out_valid=0, imem_en=0, fault=0, retired_cnt=0.
REQ-031 Reset asserted mid-fetch SHALL discard all buffered entries; first fetch after release requires start.
REQ-032 out_instr/out_pc SHALL read 0 while buffer empty after reset.

Verification
REQ-033 Reset, memory words 0..5 preloaded, start=1, out_ready=1 -> out_pc sequence 0,4,8,12,16,20 one per cycle, first out_valid two cycles after start edge, retired_cnt=6 after sixth.
REQ-034 out_ready=0 for 5 cycles after start -> exactly DEPTH pushes, then imem_en=0, pc=4*DEPTH held; release -> order preserved, no loss/duplicate.
REQ-035 Buffer holding pcs 0,4; redirect_valid=1, redirect_pc=32'h40 -> next cycle out_valid=0; following out_pc 32'h40, 32'h44.
REQ-036 redirect_pc=32'h42 -> fault=1, state FAULT, out_valid=0, later redirect to 32'h80 ignored until rst_n pulse.
REQ-037 Force pc=32'hFFFF_FFFC via redirect -> fetched entries out_pc 32'hFFFF_FFFC then 0.
REQ-038 halt_req during full buffer with out_ready=1 -> remaining entries drain, no further imem_en, start resumes at held pc.
